// File: rtl/sme_pkg.sv
// Shared types and helpers for the masked iterative carry-less multiplier.
package sme_pkg;

   typedef enum logic [1:0] {
      SME_CLMUL  = 2'd0,
      SME_CLMULH = 2'd1,
      SME_CLMULR = 2'd2
   } sme_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } sme_state_e;

   // Unordered share pair (i,k), i!=k, to a dense rng slice index for d shares.
   function automatic int pair_idx(input int i, input int k, input int d);
      int lo;
      int hi;
      lo = (i < k) ? i : k;
      hi = (i < k) ? k : i;
      return lo * d - (lo * (lo + 1)) / 2 + (hi - lo - 1);
   endfunction

endpackage

// File: rtl/sme_dom_pp.sv
// One registered DOM partial product: D-share N-bit operand a times D-share bit b.
// Every inner and cross term is registered on its own before any XOR combination.
module sme_dom_pp
   import sme_pkg::*;
#(
   parameter int D = 3,
   parameter int N = 64
) (
   input  logic                     g_clk,
   input  logic                     g_reset,
   input  logic                     en,
   input  logic                     clr,
   input  logic [D*N-1:0]           a,
   input  logic [D-1:0]             b,
   input  logic [D*(D-1)/2*N-1:0]   rng,
   output logic [D*N-1:0]           q
);

   logic [D*D*N-1:0] term_flat;

   for (genvar i = 0; i < D; i++) begin : g_row
      for (genvar k = 0; k < D; k++) begin : g_col
         logic [N-1:0] term_d;
         logic [N-1:0] term_q;

         if (i == k) begin : g_inner
            assign term_d = a[i*N +: N] & {N{b[k]}};
         end else begin : g_cross
            // Both shares of a pair add the same slice so it cancels in the recombined value.
            assign term_d = (a[i*N +: N] & {N{b[k]}}) ^ rng[pair_idx(i, k, D)*N +: N];
         end

         always_ff @(posedge g_clk) begin
            if (g_reset || clr) begin
               term_q <= '0;
            end else if (en) begin
               term_q <= term_d;
            end
         end

         assign term_flat[(i*D+k)*N +: N] = term_q;
      end
   end

   // Terms are only combined within the same share index, after registration.
   always_comb begin
      q = '0;
      for (int i = 0; i < D; i++) begin
         for (int k = 0; k < D; k++) begin
            q[i*N +: N] = q[i*N +: N] ^ term_flat[(i*D+k)*N +: N];
         end
      end
   end

endmodule

// File: rtl/sme_clmul_iter.sv
// Iterative masked carry-less multiplier (clmul/clmulh/clmulr), one rs2 bit per cycle.
// Result shares appear only during the single DONE cycle; otherwise rd is forced to zero.
module sme_clmul_iter
   import sme_pkg::*;
#(
   parameter  int XLEN  = 32,
   parameter  int SMAX  = 3,
   localparam int NPAIR = SMAX * (SMAX - 1) / 2,
   localparam int RW    = NPAIR * 2 * XLEN - 1,
   localparam int SW    = SMAX * XLEN - 1
) (
   input  logic          g_clk,
   input  logic          g_reset,
   output logic          g_clk_req,
   input  logic          valid,
   output logic          ready,
   input  logic          flush,
   input  logic [1:0]    mode,
   input  logic [SW:0]   rs1,
   input  logic [SW:0]   rs2,
   input  logic [RW:0]   rng,
   output logic [SW:0]   rd
);

   localparam int CW = $clog2(XLEN);
   localparam int AW = 2 * XLEN;
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

   sme_state_e           state;
   logic [CW-1:0]        cnt;
   logic [SW:0]          rs1_q;
   logic [SW:0]          rs2_q;
   logic [1:0]           mode_q;
   logic [SMAX*AW-1:0]   acc;
   logic [SMAX*AW-1:0]   a_shift;
   logic [SMAX*AW-1:0]   dom_q;
   logic [SMAX-1:0]      b_bit;
   logic                 accept;
   logic                 dom_en;
   logic                 dom_clr;
   logic                 acc_en;

   assign accept    = (state == IDLE) && valid && !flush;
   assign dom_en    = (state == RUN) && !flush;
   assign dom_clr   = flush || accept;
   // The DOM register only holds a real partial product from the second RUN cycle on.
   assign acc_en    = (((state == RUN) && (cnt != '0)) || (state == DRAIN)) && !flush;
   assign g_clk_req = (state != IDLE) || valid;

   for (genvar i = 0; i < SMAX; i++) begin : g_share
      logic [XLEN-1:0] b_share;
      assign b_share             = rs2_q[i*XLEN +: XLEN];
      assign b_bit[i]            = b_share[cnt];
      assign a_shift[i*AW +: AW] = AW'(rs1_q[i*XLEN +: XLEN]) << cnt;
   end

   sme_dom_pp #(
      .D (SMAX),
      .N (AW)
   ) u_dom (
      .g_clk   (g_clk),
      .g_reset (g_reset),
      .en      (dom_en),
      .clr     (dom_clr),
      .a       (a_shift),
      .b       (b_bit),
      .rng     (rng),
      .q       (dom_q)
   );

   // Control FSM; ready is registered so a flush in DONE cannot retract an observed pulse.
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         state  <= IDLE;
         cnt    <= '0;
         ready  <= 1'b0;
         rs1_q  <= '0;
         rs2_q  <= '0;
         mode_q <= '0;
         acc    <= '0;
      end else if (flush) begin
         state  <= IDLE;
         cnt    <= '0;
         ready  <= 1'b0;
         acc    <= '0;
      end else begin
         ready <= 1'b0;
         case (state)
            IDLE: begin
               if (valid) begin
                  rs1_q  <= rs1;
                  rs2_q  <= rs2;
                  mode_q <= mode;
                  acc    <= '0;
                  cnt    <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (acc_en) begin
                  acc <= acc ^ dom_q;
               end
               if (cnt == CNT_LAST) begin
                  state <= DRAIN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DRAIN: begin
               acc   <= acc ^ dom_q;
               ready <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      rd = '0;
      if (ready) begin
         for (int i = 0; i < SMAX; i++) begin
            case (mode_q)
               SME_CLMULH: rd[i*XLEN +: XLEN] = acc[i*AW + XLEN +: XLEN];
               SME_CLMULR: rd[i*XLEN +: XLEN] = acc[i*AW + XLEN - 1 +: XLEN];
               default:    rd[i*XLEN +: XLEN] = acc[i*AW +: XLEN];
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sme_clmul_iter.sv
// Scoreboard bench for sme_clmul_iter: random share splits and rng, golden clmul model,
// decoupled monitor checking the recombined result and the completion cycle.
module tb_sme_clmul_iter;

   localparam int XLEN = 32;
   localparam int SMAX = 3;
   localparam int LAT  = XLEN + 2;

   typedef struct packed {
      logic [XLEN-1:0] val;
      int              cyc;
   } exp_t;

   logic           g_clk;
   logic           g_reset;
   logic           g_clk_req;
   logic           valid;
   logic           ready;
   logic           flush;
   logic [1:0]     mode;
   logic [95:0]    rs1;
   logic [95:0]    rs2;
   logic [191:0]   rng;
   logic [95:0]    rd;

   exp_t            sb[$];
   int              cyc;
   int              checks;
   int              fails;
   bit              mask_phase;
   bit              first_seen;
   logic [XLEN-1:0] first_share;
   int              share_diff;

   sme_clmul_iter #(
      .XLEN (XLEN),
      .SMAX (SMAX)
   ) dut (
      .g_clk     (g_clk),
      .g_reset   (g_reset),
      .g_clk_req (g_clk_req),
      .valid     (valid),
      .ready     (ready),
      .flush     (flush),
      .mode      (mode),
      .rs1       (rs1),
      .rs2       (rs2),
      .rng       (rng),
      .rd        (rd)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   always @(posedge g_clk) cyc <= cyc + 1;

   // Fresh randomness every cycle, driven just after the active edge.
   initial begin
      rng = '0;
      forever begin
         @(posedge g_clk);
         #1;
         for (int w = 0; w < 6; w++) rng[w*32 +: 32] = $urandom;
      end
   end

   // Golden model straight from the carry-less product definition.
   function automatic logic [XLEN-1:0] clmul_ref(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                                 input logic [1:0] m);
      logic [2*XLEN-1:0] p;
      p = '0;
      for (int j = 0; j < XLEN; j++) begin
         if (b[j]) p = p ^ ({{XLEN{1'b0}}, a} << j);
      end
      case (m)
         2'd1:    return p[2*XLEN-1:XLEN];
         2'd2:    return p[2*XLEN-2:XLEN-1];
         default: return p[XLEN-1:0];
      endcase
   endfunction

   function automatic logic [XLEN-1:0] unmask(input logic [95:0] v);
      return v[31:0] ^ v[63:32] ^ v[95:64];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
      end
   endtask

   // Called just after a posedge with the DUT able to accept; splits operands into random shares.
   task automatic applyStimulus(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                input logic [1:0] m, input bit scored);
      logic [31:0] r0, r1, q0, q1;
      r0 = $urandom; r1 = $urandom; q0 = $urandom; q1 = $urandom;
      rs1   = {a ^ r0 ^ r1, r1, r0};
      rs2   = {b ^ q0 ^ q1, q1, q0};
      mode  = m;
      valid = 1'b1;
      if (scored) sb.push_back('{val: clmul_ref(a, b, m), cyc: cyc + LAT});
   endtask

   // Waits (bounded) for the ready pulse, then steps to just after the following edge.
   task automatic checkOutput(input bit drop_valid);
      int n;
      n = 0;
      do begin
         @(negedge g_clk);
         n++;
      end while (!ready && n < 100);
      if (!ready) begin
         checks++;
         fails++;
         $display("[TB] FAIL ready_timeout: got no ready in %0d cycles, required ready", n);
      end
      @(posedge g_clk);
      #1;
      if (drop_valid) valid = 1'b0;
   endtask

   // Monitor: pops the scoreboard on every ready pulse; rd must be zero otherwise.
   always @(negedge g_clk) begin
      if (ready) begin
         if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_ready: got ready=1 at cycle %0d, required no pulse", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", unmask(rd), e.val);
            check("ready_cycle", cyc, e.cyc);
            if (mask_phase) begin
               if (!first_seen) begin
                  first_seen  = 1'b1;
                  first_share = rd[31:0];
               end else if (rd[31:0] != first_share) begin
                  share_diff++;
               end
            end
         end
      end else if (!g_reset) begin
         check("rd_zero_idle", rd[31:0] | rd[63:32] | rd[95:64], 32'h0);
      end
   end

   initial begin
      int pulses;
      cyc = 0; checks = 0; fails = 0; share_diff = 0;
      mask_phase = 1'b0; first_seen = 1'b0; first_share = '0;
      g_reset = 1'b1; valid = 1'b0; flush = 1'b0; mode = '0; rs1 = '0; rs2 = '0;

      repeat (3) @(posedge g_clk);
      @(negedge g_clk);
      check("reset_ready", {31'b0, ready}, 32'h0);
      check("reset_rd", unmask(rd) | rd[31:0], 32'h0);
      check("reset_clk_req", {31'b0, g_clk_req}, 32'h0);
      @(posedge g_clk);
      #1;
      g_reset = 1'b0;
      @(posedge g_clk);
      #1;

      // Directed corner products in all three modes.
      for (int m = 0; m < 3; m++) begin
         applyStimulus(32'h0000_0003, 32'h0000_0003, 2'(m), 1'b1);
         checkOutput(1'b1);
         applyStimulus(32'h8000_0000, 32'h8000_0000, 2'(m), 1'b1);
         checkOutput(1'b1);
      end

      // Same unmasked operands under many share splittings.
      mask_phase = 1'b1;
      for (int n = 0; n < 100; n++) begin
         applyStimulus(32'hDEAD_BEEF, 32'h1234_5678, 2'd0, 1'b1);
         checkOutput(1'b1);
      end
      mask_phase = 1'b0;
      checks++;
      if (share_diff == 0) begin
         fails++;
         $display("[TB] FAIL share_variation: got %0d differing runs, required >0", share_diff);
      end

      // Flush while RUN holds cnt=10: no pulse, then a clean follow-up request.
      applyStimulus(32'h1357_9BDF, 32'h2468_ACE0, 2'd0, 1'b0);
      repeat (11) @(posedge g_clk);
      #1;
      flush = 1'b1;
      valid = 1'b0;
      @(posedge g_clk);
      #1;
      flush = 1'b0;
      pulses = 0;
      repeat (40) begin
         @(negedge g_clk);
         if (ready) pulses++;
      end
      check("flush_no_ready", pulses, 32'd0);
      @(posedge g_clk);
      #1;
      applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 2'd0, 1'b1);
      checkOutput(1'b1);

      // Reset while in DRAIN.
      applyStimulus(32'hCAFE_F00D, 32'h0BAD_1DEA, 2'd1, 1'b0);
      repeat (33) @(posedge g_clk);
      #1;
      g_reset = 1'b1;
      valid   = 1'b0;
      @(posedge g_clk);
      @(negedge g_clk);
      check("rst_drain_ready", {31'b0, ready}, 32'h0);
      check("rst_drain_rd", rd[31:0] | rd[63:32] | rd[95:64], 32'h0);
      check("rst_drain_clk_req", {31'b0, g_clk_req}, {31'b0, valid});
      @(posedge g_clk);
      #1;
      g_reset = 1'b0;

      // Flush wins over acceptance in IDLE, while clock request follows valid.
      valid = 1'b1;
      flush = 1'b1;
      @(negedge g_clk);
      check("idle_clk_req", {31'b0, g_clk_req}, 32'h1);
      @(posedge g_clk);
      #1;
      valid = 1'b0;
      flush = 1'b0;
      repeat (40) @(posedge g_clk);
      #1;

      // Back-to-back with valid held high across both operations.
      applyStimulus(32'h0F0F_1234, 32'hA5A5_0001, 2'd2, 1'b1);
      checkOutput(1'b0);
      applyStimulus(32'h7654_3210, 32'h89AB_CDEF, 2'd1, 1'b1);
      checkOutput(1'b1);

      // Random operands and modes, including the reserved encoding.
      for (int n = 0; n < 40; n++) begin
         applyStimulus($urandom, $urandom, 2'($urandom_range(0, 3)), 1'b1);
         checkOutput($urandom_range(0, 1) == 1);
      end
      valid = 1'b0;

      repeat (5) @(posedge g_clk);
      check("scoreboard_empty", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
